cnt_ce_ctrl: RTL and testbench

//  Run/step controller that generates the CE for the 32-bit cycle counter and the DLX datapath enables.

---
 rtl/cnt_ce_ctrl_pkg.sv | 18 +
 rtl/cnt_ce_ctrl_sync_edge.sv | 32 +++
 rtl/cnt_ce_ctrl.sv | 140 ++++++++++++++
 tb/tb_cnt_ce_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_ce_ctrl_pkg.sv
// Shared types for the run/step CE controller: state encodings and STATE width.
package cnt_ce_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  // BUSY is asserted while the controller is actively issuing CE.
  function automatic logic is_busy(input state_e s);
    return (s == ST_STEP) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/cnt_ce_ctrl_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with a registered rise pulse.
module cnt_ce_ctrl_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  // Shift chain, one-cycle delayed copy of the synced level, and the rise pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/cnt_ce_ctrl.sv
// Run/step controller producing the cycle-counter CE and datapath enables.
// Optional multi-cycle step bursts are built when STEP_BURST_EN is defined.
module cnt_ce_ctrl
  import cnt_ce_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BURST_LEN   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RUN_IN,
  input  logic               STEP_IN,
  input  logic               HALT,
  input  logic               BRK_EN,
  input  logic [CNT_W-1:0]   BRK_VAL,
  input  logic [CNT_W-1:0]   CNT_IN,
  output logic               CE,
  output logic               BUSY,
  output logic               BRK_HIT,
  output logic [STATE_W-1:0] STATE
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   brk_hit_q, brk_hit_d;
  logic   run_s, step_rise, run_rise_unused, step_level_unused;
  logic   hit, stop;
  logic   step_last, step_hit;

  // A zero-length burst is meaningless; keep the parameter visible in every build.
  if (BURST_LEN == 0) begin : g_burst_len_zero
  end

  cnt_ce_ctrl_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_run (
    .clk_i   (CLK),
    .rst_i   (RST),
    .d_i     (RUN_IN),
    .level_o (run_s),
    .rise_o  (run_rise_unused)
  );

  cnt_ce_ctrl_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_step (
    .clk_i   (CLK),
    .rst_i   (RST),
    .d_i     (STEP_IN),
    .level_o (step_level_unused),
    .rise_o  (step_rise)
  );

  assign hit  = BRK_EN & (CNT_IN == BRK_VAL);
  assign stop = hit | HALT;

`ifdef STEP_BURST_EN
  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);

  logic [BURST_W-1:0] burst_q, burst_d;

  // The first burst cycle ignores the compare so a step can move past a breakpoint.
  assign step_last = (burst_q == BURST_W'(1));
  assign step_hit  = hit & (burst_q != BURST_W'(BURST_LEN));

  // Burst down-counter: loaded on STEP entry, decremented every STEP cycle.
  always_comb begin
    burst_d = burst_q;
    if ((state_d == ST_STEP) && (state_q != ST_STEP)) begin
      burst_d = BURST_W'(BURST_LEN);
    end else if (state_q == ST_STEP) begin
      burst_d = burst_q - BURST_W'(1);
    end
  end

  // Burst counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) burst_q <= '0;
    else     burst_q <= burst_d;
  end
`else
  assign step_last = 1'b1;
  assign step_hit  = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: run beats step in IDLE, run release beats stop in RUN/BREAK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_s)          state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (step_hit)       state_d = ST_BREAK;
        else if (step_last) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!run_s)         state_d = ST_IDLE;
        else if (stop)      state_d = ST_BREAK;
      end
      ST_BREAK: begin
        if (!run_s)         state_d = ST_IDLE;
        else if (step_rise) state_d = ST_STEP;
      end
      default:              state_d = ST_IDLE;
    endcase
  end

  // Output decode: combinational CE, next values for the registered flags.
  always_comb begin
    CE        = 1'b0;
    busy_d    = is_busy(state_d);
    brk_hit_d = (state_d == ST_BREAK) && (state_q != ST_BREAK);
    case (state_q)
      ST_RUN:  CE = ~stop;
      ST_STEP: CE = ~(HALT | step_hit);
      default: CE = 1'b0;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q    <= 1'b0;
      brk_hit_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      brk_hit_q <= brk_hit_d;
    end
  end

  assign BUSY    = busy_q;
  assign BRK_HIT = brk_hit_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_cnt_ce_ctrl.sv
// Scoreboard bench for cnt_ce_ctrl: stimulus queues expected state transitions,
// a monitor pops and checks one entry each time STATE changes.
module tb_cnt_ce_ctrl;

  localparam int unsigned CNT_W = 32;
`ifdef STEP_BURST_EN
  localparam int STEP_LEN = 4;
`else
  localparam int STEP_LEN = 1;
`endif
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_BREAK = 2'd3;

  typedef struct {
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    int               ce;
    logic             busy;
    logic             hit;
  } exp_t;

  exp_t exp_q[$];

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             RUN_IN = 1'b0;
  logic             STEP_IN = 1'b0;
  logic             HALT = 1'b0;
  logic             BRK_EN = 1'b0;
  logic [CNT_W-1:0] BRK_VAL = '0;
  logic [CNT_W-1:0] CNT_IN;
  logic             CE, BUSY, BRK_HIT;
  logic [1:0]       STATE;

  logic             ld = 1'b0;
  logic [CNT_W-1:0] ld_val = '0;
  logic [CNT_W-1:0] cnt = '0;
  int               errors = 0;
  int               checks = 0;
  int               exp_hits = 0;
  logic             done = 1'b0;

  cnt_ce_ctrl #(.CNT_W(CNT_W), .SYNC_STAGES(2), .BURST_LEN(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RUN_IN  (RUN_IN),
    .STEP_IN (STEP_IN),
    .HALT    (HALT),
    .BRK_EN  (BRK_EN),
    .BRK_VAL (BRK_VAL),
    .CNT_IN  (CNT_IN),
    .CE      (CE),
    .BUSY    (BUSY),
    .BRK_HIT (BRK_HIT),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  // Model of the downstream cycle counter (not reset by RST, so it freezes).
  always @(posedge CLK) begin
    if (ld)      cnt <= ld_val;
    else if (CE) cnt <= cnt + CNT_W'(1);
  end
  assign CNT_IN = cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic [CNT_W-1:0] c, input int ce,
                      input logic busy, input logic hit);
    exp_t e;
    e.st = st; e.cnt = c; e.ce = ce; e.busy = busy; e.hit = hit;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim);
    int n;
    n = 0;
    while (STATE !== s) begin
      @(posedge CLK);
      #2;
      n++;
      if (n > lim) begin
        $display("FAIL wait_state: got state %0d expected %0d", STATE, s);
        $fatal(1, "state wait expired");
      end
    end
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] v, input int lim);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
      if (n > lim) begin
        $display("FAIL wait_cnt: got count %0d expected %0d", cnt, v);
        $fatal(1, "count wait expired");
      end
    end while (cnt !== v);
  endtask

  task automatic load_cnt(input logic [CNT_W-1:0] v);
    ld = 1'b1;
    ld_val = v;
    tick(1);
    ld = 1'b0;
  endtask

  // Monitor: checks async reset response and every STATE transition.
  initial begin : monitor
    logic [1:0] prev_st;
    int         seg_ce;
    int         hit_cnt;
    logic       rst_seen;
    exp_t       e;
    prev_st  = S_IDLE;
    seg_ce   = 0;
    hit_cnt  = 0;
    rst_seen = 1'b0;
    #1;
    forever begin
      @(negedge CLK or posedge RST);
      if (RST && !rst_seen) begin
        rst_seen = 1'b1;
        #1;
        chk("rst_ce", 64'(CE), 64'(0));
        chk("rst_state", 64'(STATE), 64'(S_IDLE));
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_brk_hit", 64'(BRK_HIT), 64'(0));
      end else begin
        if (!RST) rst_seen = 1'b0;
        if (STATE !== prev_st) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transition: got state %0d expected none", STATE);
          end else begin
            e = exp_q.pop_front();
            chk("state", 64'(STATE), 64'(e.st));
            chk("count", 64'(cnt), 64'(e.cnt));
            chk("ce_cycles", 64'(seg_ce), 64'(e.ce));
            chk("busy", 64'(BUSY), 64'(e.busy));
            chk("brk_hit", 64'(BRK_HIT), 64'(e.hit));
          end
          seg_ce  = 0;
          prev_st = STATE;
        end
        if (CE === 1'b1) seg_ce++;
        if (BRK_HIT === 1'b1) hit_cnt++;
        if (done) begin
          chk("pending_expect", 64'(exp_q.size()), 64'(0));
          chk("brk_hit_pulses", 64'(hit_cnt), 64'(exp_hits));
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  // Directed stimulus with hand-computed transitions.
  initial begin : stimulus
    #3 RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(2);

    // Single step (or burst): one rising edge held for many cycles.
    load_cnt(32'd0);
    push(S_STEP, 32'd0, 0, 1'b1, 1'b0);
    push(S_IDLE, CNT_W'(STEP_LEN), STEP_LEN, 1'b0, 1'b0);
    STEP_IN = 1'b1;
    tick(12);
    STEP_IN = 1'b0;
    wait_state(S_IDLE, 10);
    tick(5);

    // Breakpoint at 100 from count 0, then step past it.
    BRK_EN  = 1'b1;
    BRK_VAL = 32'd100;
    load_cnt(32'd0);
    push(S_RUN, 32'd0, 0, 1'b1, 1'b0);
    push(S_BREAK, 32'd100, 100, 1'b0, 1'b1);
    exp_hits++;
    RUN_IN = 1'b1;
    wait_state(S_BREAK, 200);
    tick(3);
    push(S_STEP, 32'd100, 0, 1'b1, 1'b0);
    push(S_IDLE, CNT_W'(100 + STEP_LEN), STEP_LEN, 1'b0, 1'b0);
    STEP_IN = 1'b1;
    tick(2);
    RUN_IN = 1'b0;
    wait_state(S_IDLE, 20);
    STEP_IN = 1'b0;
    tick(6);

    // HALT at count 57 while running.
    BRK_EN = 1'b0;
    load_cnt(32'd0);
    push(S_RUN, 32'd0, 0, 1'b1, 1'b0);
    push(S_BREAK, 32'd57, 57, 1'b0, 1'b1);
    push(S_IDLE, 32'd57, 0, 1'b0, 1'b0);
    exp_hits++;
    RUN_IN = 1'b1;
    wait_cnt(32'd57, 100);
    HALT = 1'b1;
    tick(3);
    HALT = 1'b0;
    tick(2);
    RUN_IN = 1'b0;
    wait_state(S_IDLE, 10);
    tick(4);

    // Wrap through zero, break at 1.
    BRK_EN  = 1'b1;
    BRK_VAL = 32'd1;
    load_cnt(32'hFFFF_FFFE);
    push(S_RUN, 32'hFFFF_FFFE, 0, 1'b1, 1'b0);
    push(S_BREAK, 32'd1, 3, 1'b0, 1'b1);
    push(S_IDLE, 32'd1, 0, 1'b0, 1'b0);
    exp_hits++;
    RUN_IN = 1'b1;
    wait_state(S_BREAK, 20);
    tick(2);
    RUN_IN = 1'b0;
    wait_state(S_IDLE, 10);
    tick(4);

    // Run and step arriving together in IDLE: run wins.
    BRK_VAL = 32'd5;
    load_cnt(32'd0);
    push(S_RUN, 32'd0, 0, 1'b1, 1'b0);
    push(S_BREAK, 32'd5, 5, 1'b0, 1'b1);
    exp_hits++;
    STEP_IN = 1'b1;
    tick(1);
    RUN_IN = 1'b1;
    wait_state(S_RUN, 10);
    tick(2);
    STEP_IN = 1'b0;
    wait_state(S_BREAK, 20);
    tick(4);

    // Run release and step together in BREAK: go to IDLE, no step.
    push(S_IDLE, 32'd5, 0, 1'b0, 1'b0);
    STEP_IN = 1'b1;
    tick(1);
    RUN_IN = 1'b0;
    tick(8);
    STEP_IN = 1'b0;
    tick(5);

    // Async reset in the middle of a run freezes the count.
    BRK_EN = 1'b0;
    load_cnt(32'd0);
    push(S_RUN, 32'd0, 0, 1'b1, 1'b0);
    push(S_IDLE, 32'd20, 20, 1'b0, 1'b0);
    RUN_IN = 1'b1;
    wait_cnt(32'd20, 100);
    RST = 1'b1;
    tick(3);
    RUN_IN = 1'b0;
    RST = 1'b0;
    tick(5);

    done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
